// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//
// Purpose:
//   Clocked front-end for the nor_latch cell. Each accepted request becomes one
//   clean set or reset pulse that is exactly PULSE_W cycles wide. After each
//   pulse comes an idle gap of DEAD_T cycles with both outputs low. The two
//   latch outputs are never high in the same cycle. The block also tracks the
//   state it last commanded the latch to hold.
//
// Parameters:
//   PULSE_W  cycles latch_set/latch_reset held high per request (>= 1)
//   DEAD_T   cycles both outputs held low after each pulse (>= 0)
//   CNT_W    phase counter width, must hold max(PULSE_W, DEAD_T)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   req_valid    in   request present
//   req_op       in   1 = set latch, 0 = reset latch (sampled on accept)
//   req_ready    out  request can be accepted this cycle (combinational)
//   latch_set    out  to latch set pin (registered)
//   latch_reset  out  to latch reset pin (registered)
//   q_expect     out  latch state last commanded (registered)
//   busy         out  FSM not in IDLE (registered)
//   q_fb         in   latch output feedback (used only with the check enabled)
//   fault        out  sticky feedback mismatch flag
//
// Configuration:
//   SR_FEEDBACK_CHECK_EN  when defined, q_fb is compared against q_expect on
//                         the edge that ends each pulse. Any mismatch sets
//                         fault, and fault stays set until rst. When undefined,
//                         fault is tied low and q_fb is ignored.
// -----------------------------------------------------------------------------
module sr_latch_driver #(
    parameter int PULSE_W = 2,
    parameter int DEAD_T  = 1,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_op,
    output logic req_ready,
    output logic latch_set,
    output logic latch_reset,
    output logic q_expect,
    output logic busy,
    input  logic q_fb,
    output logic fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    // Counter preloads. They count down to zero, so a phase of N cycles loads N-1.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD  = (DEAD_T > 0) ? CNT_W'(DEAD_T - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             set_q, set_d;
    logic             reset_q, reset_d;
    logic             q_exp_q, q_exp_d;
    logic             busy_q, busy_d;
    logic             accept;

    // req_ready is gated with rst, so nothing can be accepted while reset is held.
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            set_q   <= 1'b0;
            reset_q <= 1'b0;
            q_exp_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
            reset_q <= reset_d;
            q_exp_q <= q_exp_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (DEAD_T > 0) begin
                    state_d = DEAD;
                    cnt_d   = DEAD_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            DEAD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic. It computes the values the output registers take on the
    // next edge. set_d and reset_d are only raised from IDLE, where both
    // outputs are low, and they are complements of each other. This keeps the
    // two outputs from ever being high together.
    always_comb begin
        set_d   = set_q;
        reset_d = reset_q;
        q_exp_d = q_exp_q;
        busy_d  = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    set_d   = req_op;
                    reset_d = !req_op;
                    q_exp_d = req_op;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    set_d   = 1'b0;
                    reset_d = 1'b0;
                end
            end
            default: begin
                set_d   = 1'b0;
                reset_d = 1'b0;
            end
        endcase
    end

    assign latch_set   = set_q;
    assign latch_reset = reset_q;
    assign q_expect    = q_exp_q;
    assign busy        = busy_q;

`ifdef SR_FEEDBACK_CHECK_EN
    logic fault_q, fault_d;
    logic pulse_end;

    // q_fb is sampled on the last cycle of the pulse. By then the latch has
    // had the whole pulse width to settle.
    assign pulse_end = (state_q == PULSE) && (cnt_q == '0);

    always_comb begin
        fault_d = fault_q | (pulse_end && (q_fb != q_exp_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    logic unused_q_fb;

    assign unused_q_fb = q_fb;
    assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_driver
//
// Drives two instances of the driver:
//   dut_a  default parameters (PULSE_W=2, DEAD_T=1)
//   dut_b  PULSE_W=1, DEAD_T=0
//
// The reference model describes each instance only by the cycle of its last
// accepted request and that request's operation. From the cycle distance k to
// that accept:
//   - the pulse is active when 1 <= k <= PULSE_W
//   - the block is ready again when k > PULSE_W + DEAD_T
//
// A level-sensitive latch model in the bench stands in for the nor_latch cell
// and supplies q_fb.
// -----------------------------------------------------------------------------
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic a_valid = 1'b0, a_op = 1'b0;
    logic a_ready, a_set, a_reset, a_qexp, a_busy, a_fault, a_fb;
    logic b_valid = 1'b0, b_op = 1'b0;
    logic b_ready, b_set, b_reset, b_qexp, b_busy, b_fault, b_fb;
    logic a_lq, b_lq;
    logic fb_force = 1'b0;

    sr_latch_driver dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_op(a_op),
        .req_ready(a_ready), .latch_set(a_set), .latch_reset(a_reset),
        .q_expect(a_qexp), .busy(a_busy), .q_fb(a_fb), .fault(a_fault)
    );

    sr_latch_driver #(.PULSE_W(1), .DEAD_T(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_op(b_op),
        .req_ready(b_ready), .latch_set(b_set), .latch_reset(b_reset),
        .q_expect(b_qexp), .busy(b_busy), .q_fb(b_fb), .fault(b_fault)
    );

    // Stand-in latches. They respond at once to the set and reset pins.
    always_latch begin
        if (a_set) a_lq <= 1'b1;
        else if (a_reset) a_lq <= 1'b0;
    end
    always_latch begin
        if (b_set) b_lq <= 1'b1;
        else if (b_reset) b_lq <= 1'b0;
    end
    assign a_fb = fb_force ? 1'b0 : a_lq;
    assign b_fb = b_lq;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   last_acc[2];
    bit   last_op[2];
    bit   fault_m[2];
    int   pw[2] = '{2, 1};
    int   dt[2] = '{1, 0};
    logic [5:0] obs[2];
    logic [5:0] expv[2];
    bit   acc[2];

    // Overlap invariant, checked every cycle on both instances
    always @(negedge clk) begin
        checks++;
        if ((a_set && a_reset) || (b_set && b_reset)) begin
            errors++;
            $display("FAIL overlap cycle %0d: a set/reset=%b%b b set/reset=%b%b, required never both 1",
                     cyc, a_set, a_reset, b_set, b_reset);
        end
    end

    // Expected vector {ready, busy, set, reset, q_expect, fault}
    function automatic logic [5:0] model(input int s);
        int k = cyc - last_acc[s];
        bit pulse = (k >= 1) && (k <= pw[s]);
        bit rdy = k > (pw[s] + dt[s]);
        return {rdy, !rdy, pulse && last_op[s], pulse && !last_op[s], last_op[s], fault_m[s]};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            last_acc[s] = -1000;
            last_op[s]  = 1'b0;
            fault_m[s]  = 1'b0;
        end
    endtask

    // One cycle. At the falling edge, capture the outputs and the model's
    // expectation, then drive new inputs and advance the model.
    task automatic tick(input bit va, input bit oa, input bit vb, input bit ob);
        @(negedge clk);
        obs[0]  = {a_ready, a_busy, a_set, a_reset, a_qexp, a_fault};
        obs[1]  = {b_ready, b_busy, b_set, b_reset, b_qexp, b_fault};
        expv[0] = model(0);
        expv[1] = model(1);
        a_valid = va; a_op = oa; b_valid = vb; b_op = ob;
        for (int s = 0; s < 2; s++) begin
            int k = cyc - last_acc[s];
            bit v = (s == 0) ? va : vb;
            bit o = (s == 0) ? oa : ob;
            acc[s] = 1'b0;
`ifdef SR_FEEDBACK_CHECK_EN
            // A healthy latch reads back last_op at the end of the pulse. The
            // forced feedback is 0, so it mismatches only after a set request.
            if (k == pw[s] && s == 0 && fb_force && last_op[s]) fault_m[s] = 1'b1;
`endif
            if (v && expv[s][5] && k > 0) begin
                last_acc[s] = cyc;
                last_op[s]  = o;
                acc[s]      = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        a_valid = 0; b_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_ready, a_busy, a_set, a_reset, a_qexp, a_fault} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold_a: got %b required 000000",
                     {a_ready, a_busy, a_set, a_reset, a_qexp, a_fault});
        end
        checks++;
        if ({b_ready, b_busy, b_set, b_reset, b_qexp, b_fault} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold_b: got %b required 000000",
                     {b_ready, b_busy, b_set, b_reset, b_qexp, b_fault});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            tick(0, 0, 0, 0);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs[s] !== expv[s]) begin
                    errors++;
                    $display("FAIL reset_idle dut%0d cycle %0d: got %b required %b", s, cyc, obs[s], expv[s]);
                end
            end
        end
    endtask

    task automatic test_single_set();
        tick(1, 1, 1, 1);
        for (int i = 0; i < 7; i++) begin
            tick(0, 0, 0, 0);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs[s] !== expv[s]) begin
                    errors++;
                    $display("FAIL single_set dut%0d cycle %0d: got %b required %b", s, cyc, obs[s], expv[s]);
                end
            end
        end
        checks++;
        if (a_lq !== 1'b1) begin
            errors++;
            $display("FAIL single_set_latch_q: got %b required 1", a_lq);
        end
    endtask

    task automatic test_back_to_back();
        bit opa = 1'b0, opb = 1'b0;
        bit pa_prev = 1'b0, pb_prev = 1'b0;
        int npa = 0, npb = 0;
        for (int i = 0; i < 22; i++) begin
            tick(i < 16, opa, i < 8, opb);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs[s] !== expv[s]) begin
                    errors++;
                    $display("FAIL back_to_back dut%0d cycle %0d: got %b required %b", s, cyc, obs[s], expv[s]);
                end
            end
            if (acc[0]) opa = !opa;
            if (acc[1]) opb = !opb;
            if ((obs[0][3] || obs[0][2]) && !pa_prev) npa++;
            if ((obs[1][3] || obs[1][2]) && !pb_prev) npb++;
            pa_prev = obs[0][3] || obs[0][2];
            pb_prev = obs[1][3] || obs[1][2];
        end
        checks++;
        if (npa !== 4) begin
            errors++;
            $display("FAIL back_to_back_count_a: got %0d pulses required 4", npa);
        end
        checks++;
        if (npb !== 4) begin
            errors++;
            $display("FAIL back_to_back_count_b: got %0d pulses required 4", npb);
        end
    endtask

    task automatic test_reset_mid_pulse();
        tick(1, 1, 0, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (obs[0] !== expv[0]) begin
            errors++;
            $display("FAIL mid_pulse_pre cycle %0d: got %b required %b", cyc, obs[0], expv[0]);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({a_ready, a_busy, a_set, a_reset, a_qexp, a_fault} !== 6'b0) begin
            errors++;
            $display("FAIL mid_pulse_abort: got %b required 000000",
                     {a_ready, a_busy, a_set, a_reset, a_qexp, a_fault});
        end
        @(posedge clk);
        #2 rst = 1'b0;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs[0] !== expv[0]) begin
                errors++;
                $display("FAIL mid_pulse_after cycle %0d: got %b required %b", cyc, obs[0], expv[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs[s] !== expv[s]) begin
                    errors++;
                    $display("FAIL random dut%0d cycle %0d: got %b required %b", s, cyc, obs[s], expv[s]);
                end
            end
        end
    endtask

    task automatic test_feedback();
        bit op = 1'b0;
        fb_force = 1'b1;
        tick(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs[0] !== expv[0]) begin
                errors++;
                $display("FAIL feedback_forced cycle %0d: got %b required %b", cyc, obs[0], expv[0]);
            end
        end
        fb_force = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(1, op, 0, 0);
            if (acc[0]) op = !op;
            checks++;
            if (obs[0] !== expv[0]) begin
                errors++;
                $display("FAIL feedback_sticky cycle %0d: got %b required %b", cyc, obs[0], expv[0]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_set();
        test_back_to_back();
        test_reset_mid_pulse();
        test_random();
        test_feedback();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
